// File: rtl/ruleta_pkg.sv
// Shared types and constants for the roulette spin controller.
package ruleta_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    DECEL,
    HOLD
  } state_t;

  localparam int NUM_VALUES = 6;

  typedef logic [2:0] value_t;

  // Advance a roulette position by one, wrapping at the last position.
  function automatic value_t next_value(input value_t v, input int num_values);
    return (v == value_t'(num_values - 1)) ? value_t'(0) : value_t'(v + value_t'(1));
  endfunction

endpackage

// File: rtl/start_sync_edge.sv
// Brings the raw push button into the clk_main domain and turns each press
// into a single registered start_rise pulse, three cycles after the press.
module start_sync_edge (
  input  logic clk_main,
  input  logic reset,
  input  logic start,
  output logic start_rise
);

  logic sync_meta;
  logic sync_stable;
  logic sync_prev;

  // Two-flop synchronizer, a delayed copy, and a registered rising-edge detect.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      sync_meta   <= 1'b0;
      sync_stable <= 1'b0;
      sync_prev   <= 1'b0;
      start_rise  <= 1'b0;
    end else begin
      sync_meta   <= start;
      sync_stable <= sync_meta;
      sync_prev   <= sync_stable;
      start_rise  <= sync_stable & ~sync_prev;
    end
  end

endmodule

// File: rtl/ruleta_spin_ctrl.sv
// One roulette spin per button press: a fast constant-rate spin whose length
// depends on a free-running phase captured at the press, then a deceleration
// with growing step periods, then the result is held until the next press.
module ruleta_spin_ctrl
  import ruleta_pkg::*;
#(
  parameter int FAST_DIV   = 4,
  parameter int SPIN_STEPS = 12,
  parameter int DECEL_INC  = 2,
  parameter int SLOW_DIV   = 16,
  parameter int PHASE_W    = 3
) (
  input  logic   clk_main,
  input  logic   reset,
  input  logic   start,
  output value_t value,
  output logic   spinning,
  output logic   result_valid,
  output logic   step_pulse
);

  localparam int STEPS_W = $clog2(SPIN_STEPS + 2**PHASE_W);
  localparam int CNT_W   = $clog2(SLOW_DIV + 1);

  if ((SLOW_DIV <= FAST_DIV) || (((SLOW_DIV - FAST_DIV) % DECEL_INC) != 0)) begin : g_param_check
    $error("ruleta_spin_ctrl: SLOW_DIV must exceed FAST_DIV by a multiple of DECEL_INC");
  end

  logic               start_rise;
  state_t             state;
  state_t             state_next;
  logic [PHASE_W-1:0] phase;
  logic [STEPS_W-1:0] steps_left;
  logic [STEPS_W-1:0] steps_left_next;
  logic [CNT_W-1:0]   tick;
  logic [CNT_W-1:0]   tick_next;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   period_next;
  value_t             value_next;
  logic               step_next;

  start_sync_edge u_start_sync_edge (
    .clk_main   (clk_main),
    .reset      (reset),
    .start      (start),
    .start_rise (start_rise)
  );

  // Free-running phase counter; its value at the press is the only entropy.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else begin
      phase <= phase + PHASE_W'(1);
    end
  end

  // State, counters and registered outputs all update together on the clock edge.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      steps_left   <= '0;
      tick         <= '0;
      period       <= '0;
      value        <= '0;
      step_pulse   <= 1'b0;
      spinning     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_next;
      steps_left   <= steps_left_next;
      tick         <= tick_next;
      period       <= period_next;
      value        <= value_next;
      step_pulse   <= step_next;
      spinning     <= (state_next == SPIN) || (state_next == DECEL);
      result_valid <= (state_next == HOLD);
    end
  end

  // Next-state and datapath: presses only count when idle or holding a result.
  always_comb begin
    state_next      = state;
    steps_left_next = steps_left;
    tick_next       = tick;
    period_next     = period;
    value_next      = value;
    step_next       = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (start_rise) begin
          state_next      = SPIN;
          steps_left_next = STEPS_W'(SPIN_STEPS) + STEPS_W'(phase);
          tick_next       = '0;
        end
      end
      SPIN: begin
        if (tick == CNT_W'(FAST_DIV - 1)) begin
          tick_next       = '0;
          value_next      = next_value(value, NUM_VALUES);
          step_next       = 1'b1;
          steps_left_next = steps_left - STEPS_W'(1);
          if (steps_left == STEPS_W'(1)) begin
            state_next  = DECEL;
            period_next = CNT_W'(FAST_DIV + DECEL_INC);
          end
        end else begin
          tick_next = tick + CNT_W'(1);
        end
      end
      DECEL: begin
        if (tick == period - CNT_W'(1)) begin
          tick_next  = '0;
          value_next = next_value(value, NUM_VALUES);
          step_next  = 1'b1;
          if (period == CNT_W'(SLOW_DIV)) begin
            state_next = HOLD;
          end else begin
            period_next = period + CNT_W'(DECEL_INC);
          end
        end else begin
          tick_next = tick + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ruleta_spin_ctrl.sv
// Scoreboard bench for ruleta_spin_ctrl: stimulus queues the expected value
// of every step and the final result; a negedge monitor checks them.
module tb_ruleta_spin_ctrl;
  import ruleta_pkg::*;

  localparam int KIND_STEP = 0;
  localparam int KIND_DONE = 1;

  typedef struct {
    int kind;
    int data;
    int steps;
    int cycles;
  } exp_t;

  logic   clk_main;
  logic   reset;
  logic   start;
  value_t value;
  logic   spinning;
  logic   result_valid;
  logic   step_pulse;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   done_count = 0;
  int   tb_phase   = 0;

  int     steps_seen  = 0;
  int     spin_cycles = 0;
  logic   prev_rv     = 1'b0;
  logic   prev_step   = 1'b0;
  value_t prev_value  = '0;

  ruleta_spin_ctrl dut (
    .clk_main     (clk_main),
    .reset        (reset),
    .start        (start),
    .value        (value),
    .spinning     (spinning),
    .result_valid (result_valid),
    .step_pulse   (step_pulse)
  );

  // 10 ns clock
  initial clk_main = 1'b0;
  always #5 clk_main = ~clk_main;

  // Expected press-timing phase: counts edges since reset release, mod 8.
  always @(posedge clk_main or negedge reset) begin
    if (!reset) tb_phase <= 0;
    else        tb_phase <= (tb_phase + 1) % 8;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Queue the whole expected spin, then press start so the captured phase equals want_phase.
  task automatic applyStimulus(input int want_phase, input int from_value, input int exp_steps,
                               input int exp_cycles, input int exp_final);
    exp_t e;
    int   target;
    for (int i = 1; i <= exp_steps; i++) begin
      e.kind = KIND_STEP; e.data = (from_value + i) % 6; e.steps = 0; e.cycles = 0;
      exp_q.push_back(e);
    end
    e.kind = KIND_DONE; e.data = exp_final; e.steps = exp_steps; e.cycles = exp_cycles;
    exp_q.push_back(e);
    target = (want_phase + 8 - 3) % 8;
    do begin
      @(posedge clk_main);
      #1;
    end while (tb_phase != target);
    start = 1'b1;
  endtask

  task automatic waitDone(input int target, input int limit);
    int waited = 0;
    while (done_count < target && waited < limit) begin
      @(posedge clk_main);
      waited++;
    end
    checkOutput("done_seen", int'(done_count >= target), 1);
  endtask

  task automatic checkHeld(input int exp_final);
    @(posedge clk_main);
    #1;
    checkOutput("held_spinning", int'(spinning), 0);
    checkOutput("held_result_valid", int'(result_valid), 1);
    checkOutput("held_value", int'(value), exp_final);
  endtask

  // Monitor: every step pulse and every rising result_valid pops the scoreboard.
  always @(negedge clk_main) begin
    exp_t e;
    if (!reset) begin
      steps_seen  = 0;
      spin_cycles = 0;
      prev_rv     = 1'b0;
      prev_step   = 1'b0;
      prev_value  = value;
    end else begin
      if (spinning) spin_cycles++;
      if (step_pulse) begin
        checkOutput("step_width", int'(prev_step), 0);
        checkOutput("step_legal", int'(spinning || (result_valid && !prev_rv)), 1);
        checkOutput("step_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("step_kind", e.kind, KIND_STEP);
          checkOutput("step_value", int'(value), e.data);
        end
        steps_seen++;
      end
      if (result_valid && prev_rv) begin
        checkOutput("hold_frozen", int'(value), int'(prev_value));
      end
      if (result_valid && !prev_rv) begin
        checkOutput("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("done_kind", e.kind, KIND_DONE);
          checkOutput("final_value", int'(value), e.data);
          checkOutput("total_steps", steps_seen, e.steps);
          checkOutput("spin_cycles", spin_cycles, e.cycles);
        end
        done_count++;
        steps_seen  = 0;
        spin_cycles = 0;
      end
      prev_rv    = result_valid;
      prev_step  = step_pulse;
      prev_value = value;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int target;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk_main);
    #1;
    checkOutput("reset_value", int'(value), 0);
    checkOutput("reset_spinning", int'(spinning), 0);
    checkOutput("reset_result_valid", int'(result_valid), 0);
    checkOutput("reset_step_pulse", int'(step_pulse), 0);
    @(posedge clk_main);
    #1 reset = 1'b1;

    $display("[TB] spin A: phase 0 from 0");
    target = done_count + 1;
    applyStimulus(0, 0, 18, 114, 0);
    repeat (5) @(posedge clk_main);
    #1 start = 1'b0;
    waitDone(target, 400);
    checkHeld(0);

    $display("[TB] spin B: phase 3 from 0");
    target = done_count + 1;
    applyStimulus(3, 0, 21, 126, 3);
    repeat (5) @(posedge clk_main);
    #1 start = 1'b0;
    waitDone(target, 400);
    checkHeld(3);

    $display("[TB] spin C: phase 5 from 3, toggles mid-spin, start held through HOLD");
    target = done_count + 1;
    applyStimulus(5, 3, 23, 134, 2);
    repeat (20) @(posedge clk_main);
    for (int t = 0; t < 4; t++) begin
      #1 start = 1'b0;
      repeat (3) @(posedge clk_main);
      #1 start = 1'b1;
      repeat (3) @(posedge clk_main);
    end
    waitDone(target, 400);
    repeat (40) @(posedge clk_main);
    #1;
    checkOutput("no_retrigger_rv", int'(result_valid), 1);
    checkOutput("no_retrigger_value", int'(value), 2);
    checkOutput("no_retrigger_spin", int'(spinning), 0);
    start = 1'b0;
    repeat (5) @(posedge clk_main);

    $display("[TB] spin D: aborted by reset during deceleration");
    applyStimulus(0, 2, 18, 114, 2);
    repeat (5) @(posedge clk_main);
    #1 start = 1'b0;
    repeat (75) @(posedge clk_main);
    #1;
    checkOutput("mid_decel_spinning", int'(spinning), 1);
    reset = 1'b0;
    #2;
    exp_q.delete();
    checkOutput("abort_value", int'(value), 0);
    checkOutput("abort_spinning", int'(spinning), 0);
    checkOutput("abort_result_valid", int'(result_valid), 0);
    repeat (3) @(posedge clk_main);
    #1 reset = 1'b1;
    @(posedge clk_main);
    #1;
    checkOutput("after_reset_spinning", int'(spinning), 0);
    checkOutput("after_reset_value", int'(value), 0);

    $display("[TB] spin E: phase 3 from 0 after reset");
    target = done_count + 1;
    applyStimulus(3, 0, 21, 126, 3);
    repeat (5) @(posedge clk_main);
    #1 start = 1'b0;
    waitDone(target, 400);
    checkHeld(3);
    repeat (10) @(posedge clk_main);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
